// File: rtl/bus_split_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_split_arbiter
// Description : Bus A arbiter for NUM_INIT initiators. It supports a single
//               outstanding split transaction. When the addressed target
//               answers a granted transfer with split_ack, the bus is
//               released. The split initiator is then blocked until the
//               split target raises split_req. At that point the bus is
//               re-granted to the split initiator, with a one-cycle
//               split_grant pulse, so the read data can be returned.
//
// Parameters  : NUM_INIT       - number of initiators (2..8)
//               RR_EN          - 1 = round robin, 0 = fixed priority (lowest
//                                index wins)
//               TIMEOUT_CYCLES - watchdog limit for a granted transfer
//
// Ports       : clk, rst_n     - rising-edge clock, async active-low reset
//               req            - per-initiator bus request (level)
//               ack            - transfer-complete pulse from the target
//               split_ack      - target accepted and split the request
//               split_req      - split target has response data ready
//               grant          - one-hot registered bus grant
//               split_grant    - one-cycle pulse, bus returned for the split
//               bus_busy       - bus owned (state != ARB_IDLE)
//               split_pending  - a split is outstanding
//               split_owner    - initiator waiting on the split
//               split_overflow - sticky: split_ack while a split pending
//               timeout        - one-cycle pulse on watchdog release
//
// Optional    : define BUS_SPLIT_ARB_TIMEOUT_EN to build the watchdog.
//               Without it, timeout is tied low and no counter exists.
//
// Revision    : 1.0 - initial release
// ============================================================================
module bus_split_arbiter #(
    parameter int NUM_INIT       = 2,
    parameter int RR_EN          = 1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INIT-1:0]         req,
    input  logic                        ack,
    input  logic                        split_ack,
    input  logic                        split_req,
    output logic [NUM_INIT-1:0]         grant,
    output logic                        split_grant,
    output logic                        bus_busy,
    output logic                        split_pending,
    output logic [$clog2(NUM_INIT)-1:0] split_owner,
    output logic                        split_overflow,
    output logic                        timeout
);

    localparam int                  c_IDX_W = $clog2(NUM_INIT);
    localparam logic [NUM_INIT-1:0] c_ONE   = {{(NUM_INIT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY   = 2'd1,
        ARB_RESUME = 2'd2
    } arb_state_t;

    arb_state_t          r_state, w_state_nxt;
    logic [NUM_INIT-1:0] r_grant, w_grant_nxt;
    logic                r_split_grant, w_split_grant_nxt;
    logic                r_pend, w_pend_nxt;
    logic [c_IDX_W-1:0]  r_owner, w_owner_nxt;
    logic                r_ovf, w_ovf_nxt;
    logic [c_IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic                w_timeout_nxt;
    logic                w_expired;

    // Candidate selection
    logic [NUM_INIT-1:0] w_owner_mask;
    logic [NUM_INIT-1:0] w_cand;
    logic                w_lo_found, w_hi_found, w_win_found;
    logic [c_IDX_W-1:0]  w_lo_idx, w_hi_idx, w_win_idx;

    // The initiator blocked on a split cannot win a fresh grant.
    assign w_owner_mask = r_pend ? (c_ONE << r_owner) : '0;
    assign w_cand       = req & ~w_owner_mask;

    // Descending scan: w_lo_* ends at the lowest candidate.
    // w_hi_* ends at the lowest candidate above the round-robin pointer.
    // When nothing lies above the pointer, the search wraps. The lowest
    // candidate overall is then the round-robin winner as well.
    always_comb begin
        w_lo_found = 1'b0;
        w_hi_found = 1'b0;
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        for (int k = NUM_INIT - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = c_IDX_W'(k);
                if (k > int'(r_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_IDX_W'(k);
                end
            end
        end
    end

    assign w_win_found = w_lo_found;
    assign w_win_idx   = ((RR_EN != 0) && w_hi_found) ? w_hi_idx : w_lo_idx;

`ifdef BUS_SPLIT_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout;

    // The count is held at zero in idle, so it restarts on every grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
            if (r_state == ARB_IDLE) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            end
        end
    end

    assign w_expired = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = r_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0) ^ w_timeout_nxt;
    assign w_expired    = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_split_grant <= 1'b0;
            r_pend        <= 1'b0;
            r_owner       <= '0;
            r_ovf         <= 1'b0;
            r_ptr         <= c_IDX_W'(NUM_INIT - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_split_grant <= w_split_grant_nxt;
            r_pend        <= w_pend_nxt;
            r_owner       <= w_owner_nxt;
            r_ovf         <= w_ovf_nxt;
            r_ptr         <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_split_grant_nxt = 1'b0;
        w_pend_nxt        = r_pend;
        w_owner_nxt       = r_owner;
        w_ovf_nxt         = r_ovf;
        w_ptr_nxt         = r_ptr;
        w_timeout_nxt     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // A ready split response outranks every new request.
                if (r_pend && split_req) begin
                    w_state_nxt       = ARB_RESUME;
                    w_grant_nxt       = c_ONE << r_owner;
                    w_split_grant_nxt = 1'b1;
                end else if (w_win_found) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = c_ONE << w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                end
            end
            ARB_BUSY: begin
                // The pointer holds the current owner while busy.
                // An unmapped address pulses ack and split_ack together.
                // That case counts as a completed transfer.
                if (ack) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end else if (split_ack) begin
                    if (r_pend) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_pend_nxt  = 1'b1;
                        w_owner_nxt = r_ptr;
                    end
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ARB_IDLE;
                    w_grant_nxt   = '0;
                end else if (!req[r_ptr]) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                end
            end
            ARB_RESUME: begin
                if (ack) begin
                    w_state_nxt = ARB_IDLE;
                    w_grant_nxt = '0;
                    w_pend_nxt  = 1'b0;
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ARB_IDLE;
                    w_grant_nxt   = '0;
                    w_pend_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant          = r_grant;
    assign split_grant    = r_split_grant;
    assign bus_busy       = (r_state != ARB_IDLE);
    assign split_pending  = r_pend;
    assign split_owner    = r_owner;
    assign split_overflow = r_ovf;

endmodule
`default_nettype wire
